// File: rtl/tinyqv_mem_arbiter.sv
// tinyqv_mem_arbiter: shares the memory controller data port between the CPU
// load/store unit (m0) and a secondary master (m1). Arbitration happens only
// from IDLE. A grant is held across continue bursts for up to MAX_BURST beats.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-break;
// otherwise ties use fixed priority with m0 winning.
module tinyqv_mem_arbiter #(
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        rstn,

  input  logic [24:0] m0_addr,
  input  logic [1:0]  m0_write_n,
  input  logic [1:0]  m0_read_n,
  input  logic [31:0] m0_wdata,
  input  logic        m0_continue,
  output logic        m0_ready,

  input  logic [24:0] m1_addr,
  input  logic [1:0]  m1_write_n,
  input  logic [1:0]  m1_read_n,
  input  logic [31:0] m1_wdata,
  input  logic        m1_continue,
  output logic        m1_ready,

  output logic [31:0] m_rdata,

  output logic [24:0] data_addr,
  output logic [1:0]  data_write_n,
  output logic [1:0]  data_read_n,
  output logic [31:0] data_to_write,
  output logic        data_continue,
  input  logic        data_ready,
  input  logic [31:0] data_from_read,

  output logic [1:0]  grant
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  state_t        state;
  logic [BW-1:0] beat_cnt;

  logic req0, req1, cur_req, at_limit, pick1;

  assign req0     = (m0_read_n != 2'b11) || (m0_write_n != 2'b11);
  assign req1     = (m1_read_n != 2'b11) || (m1_write_n != 2'b11);
  assign at_limit = (beat_cnt == LAST_BEAT);
  assign cur_req  = (state == G0) ? req0 : (state == G1) ? req1 : 1'b0;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last = 1 means m1 was granted most recently, so m0 wins the next tie.
  logic last;
  assign pick1 = req1 && (!req0 || !last);
`else
  assign pick1 = req1 && !req0;
`endif

  assign grant    = state;
  assign m0_ready = data_ready && (state == G0);
  assign m1_ready = data_ready && (state == G1);
  assign m_rdata  = data_from_read;

  // Downstream port follows the granted master; idle values otherwise.
  always_comb begin
    data_addr     = '0;
    data_write_n  = 2'b11;
    data_read_n   = 2'b11;
    data_to_write = '0;
    data_continue = 1'b0;
    case (state)
      G0: begin
        data_addr     = m0_addr;
        data_write_n  = m0_write_n;
        data_read_n   = m0_read_n;
        data_to_write = m0_wdata;
        data_continue = m0_continue && !at_limit;
      end
      G1: begin
        data_addr     = m1_addr;
        data_write_n  = m1_write_n;
        data_read_n   = m1_read_n;
        data_to_write = m1_wdata;
        data_continue = m1_continue && !at_limit;
      end
      default: ;
    endcase
  end

  // Grant FSM: arbitrate in IDLE, hold through continue beats, release on
  // final ready, burst limit or abort. Release always passes through IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      beat_cnt <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last     <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (req0 || req1) begin
            state <= pick1 ? G1 : G0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last  <= pick1;
`endif
          end
        end
        G0, G1: begin
          if (!cur_req) begin
            state    <= IDLE;
            beat_cnt <= '0;
          end else if (data_ready) begin
            if (data_continue) begin
              beat_cnt <= beat_cnt + 1'b1;
            end else begin
              state    <= IDLE;
              beat_cnt <= '0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/tinyqv_mem_arbiter.md
# tinyqv_mem_arbiter

Two-master arbiter for the data port of the TinyQV memory controller. It shares the single QSPI data path between the CPU load/store unit (port 0) and a secondary master such as DMA or debug (port 1). Arbitration happens only between transactions. A grant is held across `continue` bursts up to a configurable beat limit. The block sits directly in front of the memory controller's `data_*` inputs; instruction fetch bypasses it.

## Interface
Parameters:
- `MAX_BURST`, default 8: maximum data beats per grant while `continue` is held. Must be at least 1; a value of 1 forces every beat to be a separate transaction.

Ports:
- `clk`  in  1  single clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `m0_addr`, `m1_addr`  in  25  byte address.
- `m0_write_n`, `m1_write_n`  in  2  11 = none, 00/01/10 = 8/16/32-bit write.
- `m0_read_n`, `m1_read_n`  in  2  11 = none, 00/01/10 = 8/16/32-bit read.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_continue`, `m1_continue`  in  1  next access follows at the next address.
- `m0_ready`, `m1_ready`  out  1  transaction complete for this master.
- `m_rdata`  out  32  read data shared by both masters; valid only with that master's ready.
- `data_addr`  out  25  to the memory controller.
- `data_write_n`, `data_read_n`  out  2  to the memory controller.
- `data_to_write`  out  32  to the memory controller.
- `data_continue`  out  1  to the memory controller.
- `data_ready`  in  1  from the memory controller.
- `data_from_read`  in  32  from the memory controller.
- `grant`  out  2  one-hot current owner: 01 = m0, 10 = m1, 00 = idle. Also used for debug.

## Operation
- A master requests when `mX_read_n != 11` or `mX_write_n != 11`. It must hold the request stable until its `mX_ready`.
- FSM states: IDLE, G0, G1. The state is registered and `grant` reflects it directly.
- IDLE: downstream outputs are `data_read_n = data_write_n = 11`, `data_continue = 0`, `data_addr = 0`, `data_to_write = 0`.
  - If any request is present, go to G0 or G1 per the priority rule.
  - If both masters request, the priority rule picks the winner.
- G0/G1: the granted master's `addr`, `read_n`, `write_n`, `wdata` and continue (gated) drive the downstream port combinationally.
  - `data_continue = mX_continue && (beat_cnt != MAX_BURST-1)`.
  - `mX_ready = data_ready && grant[X]`.
  - `m_rdata = data_from_read` in all states.
- Release conditions:
  - On `data_ready` with gated `data_continue = 0`, go to IDLE at that edge.
  - On `data_ready` with `data_continue = 1`, stay in the grant state and increment `beat_cnt`.
  - If the granted master drops both `read_n` and `write_n` to 11 before ready (abort), go to IDLE at the next edge. No ready is issued.
- `beat_cnt`: width `$clog2(MAX_BURST)` (minimum 1). It clears on entry to IDLE and never wraps past `MAX_BURST-1`.
- Burst cut: when the limit is reached, the requester still holds continue, but the transaction ends downstream. If the master keeps requesting at the next address, it re-enters arbitration from IDLE.
- A non-granted master sees ready = 0 and waits; no data is lost.

## Timing
- Reset values while `rstn` is low:
  - state IDLE, `grant = 00`, `beat_cnt = 0`.
  - `m0_ready = m1_ready = 0`.
  - `data_read_n = data_write_n = 11`, `data_continue = 0`.
  - An assertion mid-transaction returns the block to IDLE immediately, asynchronously.
- Grant latency is 1 cycle: a request seen in IDLE at edge N drives the downstream port from edge N onward. The memory controller can start a transaction in cycle N+1 at the earliest.
- Ready is combinational from `data_ready`, with zero added latency.
- After a non-continue ready, the downstream port is idle for at least 1 cycle (IDLE) before the next grant.
- If a new request and a release occur in the same cycle, the release takes effect first. The new request is arbitrated in the following IDLE cycle.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - The arbiter keeps a `last` flag, updated on every grant.
  - On a simultaneous request, the master not granted last wins.
  - Reset value of `last` = m1, so m0 wins the first tie.
- `MEM_ARB_ROUND_ROBIN_EN` undefined: fixed priority, with m0 (CPU) always winning a tie. There is no `last` register.

## Test plan
- **Single read:** m0 requests a 32-bit read (`read_n = 10`) at 0x000100 and the model returns 0xDEADBEEF.
  - `grant` goes to 01 one cycle later.
  - `m0_ready` pulses once with `m_rdata = 0xDEADBEEF`.
  - `grant` returns to 00.
- **Tie:** m0 and m1 both request in the same IDLE cycle.
  - Fixed priority: m0 is served first, then m1.
  - With `MEM_ARB_ROUND_ROBIN_EN`, a second tie immediately after is served m1 first.
- **Burst limit:** with `MAX_BURST = 4`, m1 writes 6 words with `continue = 1`.
  - `data_continue` drops on beat 4.
  - `grant` goes 10 → 00 → 10.
  - Beats 5–6 complete, for 6 `m1_ready` pulses in total.
- **Hold while busy:** m1 requests during an m0 burst of 3 beats.
  - `m1_ready` stays 0 until m0 releases.
  - m1's downstream request appears no earlier than one cycle after the IDLE cycle.
- **Abort:** m0 drops its request before ready.
  - `grant = 00` at the next edge.
  - No `m0_ready` is issued, and a pending m1 request is granted afterwards.
- **Reset mid-operation:** assert `rstn` low during a G1 write.
  - Outputs return to reset values within the same cycle.
  - After release, no ready is issued until a fresh request arrives.
